// File: rtl/fetch_pipe.sv
// fetch_pipe: instruction-fetch stage that owns the fetch PC, issues req/ack memory
// requests and buffers returned words in a shift-register FIFO.
module fetch_pipe #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              err
);

    // Handshakes: a memory request completes in any cycle with imem_req & imem_ack, and
    // decode takes the head in any cycle with instr_valid & instr_ready; neither side
    // may withdraw or change an offered request/word until that cycle.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              discard_q, discard_d;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] pcs_q  [DEPTH];
    logic [ADDR_W-1:0] pcs_d  [DEPTH];

    logic              pop, complete, push, start;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [IDX_W-1:0]  wr_idx;

    assign pop          = valid_q & instr_ready;
    assign complete     = (state_q == BUSY) & imem_ack;
    assign push         = complete & ~discard_q & ~redirect_valid;
    assign redirect_tgt = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign wr_idx       = IDX_W'(count_q - CNT_W'(pop));

    // A new request may only start if the slot it will fill is already free next cycle.
    always_comb begin
        count_d = count_q - CNT_W'(pop) + CNT_W'(push);
        if (redirect_valid) begin
            count_d = '0;
        end
        start = ~halt & (count_d <= CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            discard_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
            valid_q    <= (count_d != '0);
            err_q      <= err_q | (redirect_valid & redirect_pc[0]);
            data_q     <= data_d;
            pcs_q      <= pcs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? BUSY : IDLE;
            BUSY:    if (complete) state_d = start ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
        end else if (push) begin
            fetch_pc_d = addr_q + ADDR_W'(PC_INC);
        end

        // The address only moves when a fresh request is launched.
        addr_d = addr_q;
        if (((state_q == IDLE) || complete) && start) begin
            addr_d = fetch_pc_d;
        end

        discard_d = discard_q;
        if (complete) begin
            discard_d = 1'b0;
        end else if ((state_q == BUSY) && redirect_valid) begin
            discard_d = 1'b1;
        end

        data_d = data_q;
        pcs_d  = pcs_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_d[i] = data_q[i+1];
                pcs_d[i]  = pcs_q[i+1];
            end
        end
        if (push) begin
            data_d[wr_idx] = imem_rdata;
            pcs_d[wr_idx]  = addr_q;
        end
    end

    assign imem_req    = (state_q == BUSY);
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = data_q[0];
    assign instr_pc    = pcs_q[0];
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Testbench for fetch_pipe: directed scenario tasks plus a randomized run, all
// watched by a queue-based model of the expected decode stream.
module tb_fetch_pipe;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int PC_INC = 2;

    logic              clk;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              err;

    int checks = 0;
    int errors = 0;

    fetch_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_INC(PC_INC), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    logic [DATA_W-1:0] mem_key = 16'hA5A5;
    int                ack_lat = 0;
    int                req_age = 0;

    task automatic tick();
        logic done;
        done = imem_req && imem_ack;
        @(posedge clk);
        #1;
        if (!imem_req || done) req_age = 0;
        else req_age++;
        if (ack_lat != 0) imem_ack = imem_req && (req_age == ack_lat - 1);
        imem_rdata = imem_addr ^ mem_key;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        mem_key = 16'hA5A5;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [DATA_W+ADDR_W-1:0] exp_q[$];
    logic              m_known = 1'b0;
    logic [ADDR_W-1:0] m_pc;
    logic              m_discard;
    logic              m_err;
    logic              p_req, p_ack, p_halt;
    logic [ADDR_W-1:0] p_addr;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_known   = 1'b1;
            m_pc      = '0;
            m_discard = 1'b0;
            m_err     = 1'b0;
            p_req     = 1'b0;
            p_ack     = 1'b0;
            p_halt    = 1'b0;
            p_addr    = '0;
        end else if (m_known) begin
            checks++;
            if (instr_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL mon_valid: got %b expected %b", instr_valid, exp_q.size() != 0);
            end
            if (instr_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                if (instr !== exp_q[0][DATA_W+ADDR_W-1:ADDR_W] || instr_pc !== exp_q[0][ADDR_W-1:0]) begin
                    errors++;
                    $display("FAIL mon_head: got %h@%h expected %h@%h", instr, instr_pc,
                             exp_q[0][DATA_W+ADDR_W-1:ADDR_W], exp_q[0][ADDR_W-1:0]);
                end
            end
            checks++;
            if (err !== m_err) begin
                errors++;
                $display("FAIL mon_err: got %b expected %b", err, m_err);
            end
            if (p_halt && imem_req && (!p_req || p_ack)) begin
                errors++;
                $display("FAIL mon_halt: got imem_req=%b expected 0", imem_req);
            end
            if (p_req && !p_ack) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    errors++;
                    $display("FAIL mon_hold: got req=%b addr=%h expected req=1 addr=%h",
                             imem_req, imem_addr, p_addr);
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                if (imem_req && !imem_ack) m_discard = 1'b1;
                else if (imem_req && imem_ack) m_discard = 1'b0;
                m_pc = {redirect_pc[ADDR_W-1:1], 1'b0};
                if (redirect_pc[0]) m_err = 1'b1;
            end else begin
                if (instr_valid && instr_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (imem_req && imem_ack) begin
                    if (m_discard) begin
                        m_discard = 1'b0;
                    end else begin
                        checks++;
                        if (imem_addr !== m_pc) begin
                            errors++;
                            $display("FAIL mon_addr: got %h expected %h", imem_addr, m_pc);
                        end
                        exp_q.push_back({imem_rdata, m_pc});
                        m_pc = m_pc + ADDR_W'(PC_INC);
                    end
                end
            end
            if (exp_q.size() > DEPTH) begin
                errors++;
                $display("FAIL mon_overflow: got %0d entries expected at most %0d", exp_q.size(), DEPTH);
            end
            p_req  = imem_req;
            p_ack  = imem_ack;
            p_halt = halt;
            p_addr = imem_addr;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ack_lat = 0; imem_ack = 1'b1; instr_ready = 1'b1;
        do_reset();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0 ||
            instr !== 16'h0000 || instr_pc !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got req=%b addr=%h v=%b i=%h pc=%h err=%b expected all 0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, err);
        end
    endtask

    task automatic test_stream();
        logic [ADDR_W-1:0] pcs [3];
        logic [DATA_W-1:0] ins [3];
        pcs = '{16'h0000, 16'h0002, 16'h0004};
        ins = '{16'hA5A5, 16'hA5A7, 16'hA5A1};
        ack_lat = 0; imem_ack = 1'b1; instr_ready = 1'b1;
        do_reset();
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== pcs[i] || instr !== ins[i]) begin
                errors++;
                $display("FAIL stream_head%0d: got v=%b %h@%h expected 1 %h@%h",
                         i, instr_valid, instr, instr_pc, ins[i], pcs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        ack_lat = 0; imem_ack = 1'b1; instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req) reqs++;
        end
        checks++;
        if (reqs != DEPTH || imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
            errors++;
            $display("FAIL bp_fill: got reqs=%0d req=%b head=%h expected reqs=4 req=0 head=0000",
                     reqs, imem_req, instr_pc);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(2 * i)) begin
                errors++;
                $display("FAIL bp_drain%0d: got v=%b pc=%h expected 1 %h", i, instr_valid, instr_pc, 2 * i);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
                    errors++;
                    $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=0008", imem_req, imem_addr);
                end
            end
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0008) begin
            errors++;
            $display("FAIL bp_after: got v=%b pc=%h expected 1 0008", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_busy();
        int n = 0;
        ack_lat = 3; imem_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        while (!(imem_req && imem_addr == 16'h0004) && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL rb_timeout: got no request to 0004 expected one within 50 cycles");
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL rb_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=0004",
                     instr_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL rb_refetch: got v=%b req=%b addr=%h expected v=0 req=1 addr=0100",
                     instr_valid, imem_req, imem_addr);
        end
        tick(); tick(); tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr !== 16'hA4A5) begin
            errors++;
            $display("FAIL rb_first: got v=%b %h@%h expected 1 a4a5@0100", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_redirect_ack();
        ack_lat = 0; imem_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        tick(); tick();
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0031;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0030) begin
            errors++;
            $display("FAIL ra_redirect: got err=%b v=%b req=%b addr=%h expected 1 0 1 0030",
                     err, instr_valid, imem_req, imem_addr);
        end
        tick();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0030 || instr !== 16'hA595) begin
            errors++;
            $display("FAIL ra_word: got v=%b %h@%h expected 1 a595@0030", instr_valid, instr, instr_pc);
        end
        tick(); tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ra_sticky: got err=%b expected 1", err);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] pcs [3];
        pcs = '{16'hFFFC, 16'hFFFE, 16'h0000};
        ack_lat = 0; imem_ack = 1'b1; instr_ready = 1'b1;
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFC || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_req: got req=%b addr=%h v=%b expected 1 fffc 0", imem_req, imem_addr, instr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== pcs[i]) begin
                errors++;
                $display("FAIL wrap_head%0d: got v=%b pc=%h expected 1 %h", i, instr_valid, instr_pc, pcs[i]);
            end
        end
    endtask

    task automatic test_halt();
        int n = 0;
        ack_lat = 2; imem_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        while (!(imem_req && imem_addr == 16'h0004) && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL halt_timeout: got no request to 0004 expected one within 50 cycles");
        end
        halt = 1'b1;
        tick(); tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0004) begin
            errors++;
            $display("FAIL halt_complete: got req=%b v=%b pc=%h expected 0 1 0004", imem_req, instr_valid, instr_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold%0d: got req=%b expected 0", i, imem_req);
            end
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain: got v=%b expected 0", instr_valid);
        end
        halt = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            errors++;
            $display("FAIL halt_resume: got req=%b addr=%h expected 1 0006", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        ack_lat = 0; imem_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick();
            mem_key        = 16'($urandom);
            imem_rdata     = imem_addr ^ mem_key;
            imem_ack       = ($urandom_range(0, 2) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                         : 16'($urandom);
            rst            = (i == 1500) ? 1'b0 : 1'b1;
        end
        redirect_valid = 1'b0; halt = 1'b0; rst = 1'b1;
        tick(); tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_busy();
        test_redirect_ack();
        test_wrap();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pipe.md
Name: fetch_pipe

Overview:
Parametrised instruction-fetch stage that succeeds the single-cycle fetch unit. It owns the fetch PC and issues requests to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered in a FIFO of depth DEPTH and handed to decode over a valid/ready interface. It supports branch redirect with flush, halt, and PC wrap-around.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, PC / memory address width in bits
DEPTH, 4, instruction FIFO entries (power of 2, >= 2)
PC_INC, 2, byte increment between sequential fetches
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
imem_req  out  1  memory request; held high until accepted
imem_addr  out  ADDR_W  request address; stable while imem_req=1
imem_ack  in  1  request completes in a cycle with imem_req=1 and imem_ack=1
imem_rdata  in  DATA_W  instruction word; valid in the completion cycle only
instr_valid  out  1  FIFO head is valid
instr  out  DATA_W  FIFO head instruction
instr_pc  out  ADDR_W  address that head was fetched from
instr_ready  in  1  decode accepts the head when instr_valid=1 and instr_ready=1
redirect_valid  in  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  in  ADDR_W  redirect target
halt  in  1  level; while high, no new requests start
err  out  1  sticky misaligned-redirect flag

Behaviour:
- Reset (rst=0 at an edge):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, err=0.
  - FIFO count=0, discard flag=0, state=IDLE.
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
  - All outputs are registered.
- IDLE->BUSY:
  - Condition: halt=0 and a FIFO slot is reserved. The slot is reserved when occupancy next cycle (current count, minus a pop this cycle, plus a push this cycle) is at most DEPTH-1.
  - imem_req rises at the next edge, with imem_addr=fetch_pc.
- BUSY completion (imem_req & imem_ack):
  - If the discard flag is 0: push {imem_rdata, imem_addr} into the FIFO, and set fetch_pc = imem_addr + PC_INC (mod 2^ADDR_W, so 0xFFFE wraps to 0x0000).
  - If the discard flag is 1: drop the word and clear the flag.
  - If the IDLE->BUSY condition holds again, imem_req stays high with the new address (back-to-back). Otherwise go to IDLE and drop imem_req.
- Throughput and latency:
  - With imem_ack tied to 1: one instruction per cycle.
  - Ack in cycle N gives instr_valid=1 from cycle N+1.
  - First imem_req=1 is in the first cycle after rst returns to 1.
- FIFO:
  - instr, instr_pc and instr_valid come directly from head registers.
  - Push and pop in the same cycle are both performed.
  - A push never finds the FIFO full; this is guaranteed by the reservation rule.
- Redirect (redirect_valid=1):
  - FIFO is flushed at the edge: count=0 and instr_valid=0 next cycle.
  - fetch_pc = {redirect_pc[ADDR_W-1:1], 1'b0}.
  - If BUSY and not completing this cycle: set the discard flag; imem_addr is not changed mid-request.
  - If completing this cycle: the word is dropped and the flag stays 0.
  - If IDLE, or once the discarded request completes: the next request uses the redirect target.
  - Redirect beats a same-cycle pop and push; the handshake still counts as accepted by decode.
  - A second redirect while discarding overwrites fetch_pc; a single outstanding discard remains.
- err:
  - Set to 1 when redirect_valid=1 and redirect_pc[0]=1.
  - Stays 1 until reset. The redirect is still taken with bit 0 cleared.
- Halt:
  - Blocks new requests only. An outstanding request completes and pushes normally.
  - The FIFO keeps draining. Fetch resumes from fetch_pc when halt drops.
- Reset mid-request: everything returns to reset values at that edge. Any later imem_ack with imem_req=0 is ignored.
- imem_ack while imem_req=0 is ignored.

Test Plan:
1. Reset then run; imem_ack=1, instr_ready=1, memory returns addr^16'hA5A5 -> imem_req high from first post-reset cycle; instr_pc sequence 0x0000, 0x0002, 0x0004 on consecutive cycles; instr=0xA5A5, 0xA5A7, 0xA5A1.
2. instr_ready=0, DEPTH=4, ack=1 -> exactly 4 entries pushed (pc 0..6); imem_req low afterwards; raise instr_ready -> 4 pops, then fetch resumes at 0x0008.
3. Ack latency 3 cycles; redirect_valid to 0x0100 in the 2nd wait cycle of the request to 0x0004 -> word for 0x0004 dropped; FIFO empty; next imem_addr=0x0100; first instr_pc after redirect=0x0100.
4. Redirect to 0x0031 in the same cycle as an ack -> err=1 next cycle and stays high; word dropped; next imem_addr=0x0030.
5. Fetch from 0xFFFC with ack=1 -> instr_pc 0xFFFC, 0xFFFE, 0x0000.
6. halt=1 while BUSY with latency 2 -> that request completes and pushes; no further imem_req; FIFO drains; halt=0 -> next imem_addr = last pc + 2.
